// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - FIFO-buffered instruction issuer driving the s/w start handshake
// Optional watchdog: define INSTR_ISSUE_TIMEOUT_EN to enable timeout_err.
module instr_issue #(
    parameter int DEPTH = 4,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    output logic          in_ready,
    input  logic          w,
    output logic          s,
    output logic [IW-1:0] instr_out,
    output logic          busy,
    output logic          empty,
    output logic          full,
    output logic [7:0]    done_count,
    output logic          timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_d;
    logic          push, pop, complete;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;

`ifdef INSTR_ISSUE_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       timeout_q;
    logic       timeout_fire;
`endif

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        complete = 1'b0;
`ifdef INSTR_ISSUE_TIMEOUT_EN
        timeout_fire = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!empty && w) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!w) state_d = EXEC;
            end
            EXEC: begin
                if (w) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef INSTR_ISSUE_TIMEOUT_EN
        // The 255th cycle after ISSUE entry aborts the instruction without counting it
        if (state_q != IDLE && wd_cnt == 8'd254) begin
            timeout_fire = 1'b1;
            complete     = 1'b0;
            state_d      = IDLE;
        end
`endif
    end

    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = count - 1'b1;
            default: count_d = count;
        endcase
    end

    // Storage carries no reset; occupancy and pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_instr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            s          <= 1'b0;
            busy       <= 1'b0;
            instr_out  <= '0;
            done_count <= 8'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
        end else begin
            state_q <= state_d;
            // s is high exactly while the registered state is ISSUE
            s       <= (state_d == ISSUE);
            busy    <= (state_d != IDLE);
            if (pop) begin
                instr_out <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (complete) done_count <= done_count + 8'd1;
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CW'(DEPTH));
        end
    end

`ifdef INSTR_ISSUE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            if (pop) wd_cnt <= 8'd0;
            else if (state_q != IDLE) wd_cnt <= wd_cnt + 8'd1;
            if (timeout_fire) timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
